// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared types and constants for the sequential signed divider.
//   state_t         : divider FSM states (IDLE, CALC, DONE)
//   default_width   : default operand / result width
//   cnt_bits(w)     : width of the step counter needed to hold the value w
package seq_divider_pkg;

    localparam int default_width = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // The step counter is loaded with the operand width and counts down to
    // zero, so it must be able to represent the width itself.
    function automatic int cnt_bits(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   r      in   width+1  partial remainder before the step
//   q      in   width    quotient register (dividend magnitude being shifted out)
//   dmag   in   width+1  divisor magnitude
//   r_next out  width+1  partial remainder after the step
//   q_next out  width    quotient register after the step (new bit in LSB)
module div_step #(
    parameter int width = 6
) (
    input  logic [width:0]   r,
    input  logic [width-1:0] q,
    input  logic [width:0]   dmag,
    output logic [width:0]   r_next,
    output logic [width-1:0] q_next
);

    logic [width+1:0] shifted;
    logic [width:0]   trial;
    logic             fits;

    // Shift {R, Q} left by one: the MSB of Q moves into R. The partial
    // remainder stays below the divisor magnitude, so the shifted value
    // never needs more than width+1 bits; the extra top bit only keeps the
    // comparison honest.
    always_comb begin
        shifted = {r, q[width-1]};
        fits    = (shifted >= {1'b0, dmag});
        trial   = shifted[width:0] - dmag;
        r_next  = fits ? trial : shifted[width:0];
        q_next  = {q[width-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Multi-cycle signed two's-complement divider, one restoring step per clock,
// with a start/busy/done handshake. Quotient truncates toward zero and the
// remainder takes the sign of the dividend.
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request a division (only honoured in IDLE)
//   dividend     in   width  signed dividend, sampled on the accepting edge
//   divisor      in   width  signed divisor, sampled on the accepting edge
//   busy         out  1      high in CALC and DONE
//   done         out  1      one-cycle pulse, results valid while high
//   quotient     out  width  signed quotient (held until the next result)
//   remainder    out  width  signed remainder (held until the next result)
//   div_by_zero  out  1      set together with done when the divisor was 0
// Build option:
//   SEQ_DIVIDER_EARLY_EXIT_EN  finish in one cycle when |dividend| < |divisor|
//                              or |divisor| == 1; results are unchanged.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int width = default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int cw = cnt_bits(width);

    state_t           state;
    logic [cw-1:0]    count;
    logic [width:0]   rem_reg;
    logic [width-1:0] quo_reg;
    logic [width:0]   dsr_mag;
    logic             q_neg;
    logic             d_neg;

    logic [width:0]   dvd_mag_in;
    logic [width:0]   dsr_mag_in;
    logic [width:0]   r_next;
    logic [width-1:0] q_next;
    logic [width-1:0] quo_final;
    logic [width-1:0] rem_final;

    // Magnitudes are width+1 bits wide so that |-2^(width-1)| is exact;
    // sign-extending before negation makes the most negative value come out
    // as the positive power of two.
    always_comb begin
        dvd_mag_in = dividend[width-1] ? -{dividend[width-1], dividend} : {1'b0, dividend};
        dsr_mag_in = divisor[width-1]  ? -{divisor[width-1], divisor}   : {1'b0, divisor};
    end

    div_step #(
        .width (width)
    ) u_step (
        .r      (rem_reg),
        .q      (quo_reg),
        .dmag   (dsr_mag),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Sign restoration on the final step's outputs. The quotient magnitude
    // is truncated to width bits, so -2^(width-1) / -1 wraps back to
    // -2^(width-1) without any flag.
    always_comb begin
        quo_final = q_neg ? -q_next : q_next;
        rem_final = d_neg ? -r_next[width-1:0] : r_next[width-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dsr_mag     <= '0;
            q_neg       <= 1'b0;
            d_neg       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        d_neg   <= dividend[width-1];
                        q_neg   <= dividend[width-1] ^ divisor[width-1];
                        quo_reg <= dvd_mag_in[width-1:0];
                        dsr_mag <= dsr_mag_in;
                        rem_reg <= '0;
                        count   <= cw'(width);
                        busy    <= 1'b1;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
                        // Trivial cases resolved straight from the inputs.
                        else if (dvd_mag_in < dsr_mag_in) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b0;
                        end else if (dsr_mag_in == (width+1)'(1)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= divisor[width-1] ? -dividend : dividend;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= r_next;
                    quo_reg <= q_next;
                    count   <= count - cw'(1);
                    // Last step: publish the sign-corrected results directly.
                    if (count == cw'(1)) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        quotient    <= quo_final;
                        remainder   <= rem_final;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
